// File: rtl/video_mono_filter_if.sv
// Pixel bus between the system video source and the monochrome filter.
// The master side drives source pixels and the requested mode; the slave side drives the filtered pixels.
interface video_mono_filter_if #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 3
);
  logic [2:0]       mode;
  logic [IN_W-1:0]  in_r;
  logic [IN_W-1:0]  in_g;
  logic [IN_W-1:0]  in_b;
  logic             in_hsync;
  logic             in_vsync;
  logic             in_blank;
  logic [OUT_W-1:0] out_r;
  logic [OUT_W-1:0] out_g;
  logic [OUT_W-1:0] out_b;
  logic             out_hsync;
  logic             out_vsync;
  logic             out_blank;
  logic [2:0]       mode_active;

  modport master (
    output mode, in_r, in_g, in_b, in_hsync, in_vsync, in_blank,
    input  out_r, out_g, out_b, out_hsync, out_vsync, out_blank, mode_active
  );

  modport slave (
    input  mode, in_r, in_g, in_b, in_hsync, in_vsync, in_blank,
    output out_r, out_g, out_b, out_hsync, out_vsync, out_blank, mode_active
  );
endinterface

// File: rtl/video_mono_filter.sv
// Three-stage monochrome filter: BT.709 luma, per-mode composition, optional 2x2 ordered dither
// and width reduction, with syncs and blank delayed to match the pixel path.
module video_mono_filter #(
  parameter int IN_W      = 6,
  parameter int OUT_W     = 3,
  parameter int DITHER_EN = 1,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input logic                 clk_vga,
  input logic                 rst_n,
  video_mono_filter_if.slave  vid
);

  localparam int              PW        = IN_W + 8;
  localparam logic [IN_W-1:0] M         = {IN_W{1'b1}};
  localparam bit              DITHER_ON = (DITHER_EN != 0) && (IN_W - OUT_W >= 2);
  localparam int              DSH       = (IN_W - OUT_W >= 2) ? (IN_W - OUT_W - 2) : 0;

  localparam logic [2:0] MODE_GREEN = 3'd1;
  localparam logic [2:0] MODE_AMBER = 3'd2;
  localparam logic [2:0] MODE_WHITE = 3'd3;
  localparam logic [2:0] MODE_INV   = 3'd4;

  logic [IN_W-1:0]  s1_r, s1_g, s1_b;
  logic [PW-1:0]    s1_pr, s1_pg, s1_pb;
  logic             s1_hs, s1_vs, s1_bl, s1_x, s1_y;
  logic [IN_W-1:0]  s2_r, s2_g, s2_b;
  logic             s2_hs, s2_vs, s2_bl, s2_x, s2_y;
  logic [OUT_W-1:0] o_r, o_g, o_b;
  logic             o_hs, o_vs, o_bl;
  logic [2:0]       mode_active;
  logic             x_cnt, y_cnt;
  logic             vs_lead, hs_lead;
  logic [IN_W-1:0]  luma, c2_r, c2_g, c2_b;
  logic [1:0]       bayer;
  logic [IN_W-1:0]  dith;

  // Stage 1 already holds the previous input syncs, so it doubles as the edge detector.
  assign vs_lead = (vid.in_vsync == VS_POL) && (s1_vs != VS_POL);
  assign hs_lead = (vid.in_hsync == HS_POL) && (s1_hs != HS_POL);

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      x_cnt       <= 1'b0;
      y_cnt       <= 1'b0;
      mode_active <= vid.mode;
    end else begin
      x_cnt <= vid.in_blank ? 1'b0 : ~x_cnt;
      if (vs_lead) begin
        y_cnt       <= 1'b0;
        mode_active <= vid.mode;
      end else if (hs_lead) begin
        y_cnt <= ~y_cnt;
      end
    end
  end

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
      s1_pr <= '0;
      s1_pg <= '0;
      s1_pb <= '0;
      s1_hs <= ~HS_POL;
      s1_vs <= ~VS_POL;
      s1_bl <= 1'b1;
      s1_x  <= 1'b0;
      s1_y  <= 1'b0;
    end else begin
      s1_r  <= vid.in_r;
      s1_g  <= vid.in_g;
      s1_b  <= vid.in_b;
      s1_pr <= PW'(vid.in_r) * PW'(54);
      s1_pg <= PW'(vid.in_g) * PW'(183);
      s1_pb <= PW'(vid.in_b) * PW'(19);
      s1_hs <= vid.in_hsync;
      s1_vs <= vid.in_vsync;
      s1_bl <= vid.in_blank;
      s1_x  <= x_cnt;
      s1_y  <= y_cnt;
    end
  end

  // Weights sum to 256, so the shifted sum always fits back into IN_W bits.
  always_comb begin
    luma = IN_W'((s1_pr + s1_pg + s1_pb) >> 8);
    c2_r = s1_r;
    c2_g = s1_g;
    c2_b = s1_b;
    case (mode_active)
      MODE_GREEN: begin c2_r = '0;        c2_g = luma;      c2_b = '0;        end
      MODE_AMBER: begin c2_r = luma;      c2_g = luma >> 1; c2_b = '0;        end
      MODE_WHITE: begin c2_r = luma;      c2_g = luma;      c2_b = luma;      end
      MODE_INV:   begin c2_r = M - luma;  c2_g = M - luma;  c2_b = M - luma;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      s2_r  <= '0;
      s2_g  <= '0;
      s2_b  <= '0;
      s2_hs <= ~HS_POL;
      s2_vs <= ~VS_POL;
      s2_bl <= 1'b1;
      s2_x  <= 1'b0;
      s2_y  <= 1'b0;
    end else begin
      s2_r  <= c2_r;
      s2_g  <= c2_g;
      s2_b  <= c2_b;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_bl <= s1_bl;
      s2_x  <= s1_x;
      s2_y  <= s1_y;
    end
  end

  always_comb begin
    case ({s2_y, s2_x})
      2'b00:   bayer = 2'd0;
      2'b01:   bayer = 2'd2;
      2'b10:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
    dith = DITHER_ON ? (IN_W'(bayer) << DSH) : '0;
  end

  // Saturating add keeps full-scale inputs at full scale instead of wrapping to black.
  function automatic logic [OUT_W-1:0] reduce(input logic [IN_W-1:0] c, input logic [IN_W-1:0] d);
    logic [IN_W:0]   sum;
    logic [IN_W-1:0] v;
    sum = {1'b0, c} + {1'b0, d};
    v   = (sum > {1'b0, M}) ? M : sum[IN_W-1:0];
    return OUT_W'(v >> (IN_W - OUT_W));
  endfunction

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      o_r  <= '0;
      o_g  <= '0;
      o_b  <= '0;
      o_hs <= ~HS_POL;
      o_vs <= ~VS_POL;
      o_bl <= 1'b1;
    end else begin
      o_r  <= s2_bl ? '0 : reduce(s2_r, dith);
      o_g  <= s2_bl ? '0 : reduce(s2_g, dith);
      o_b  <= s2_bl ? '0 : reduce(s2_b, dith);
      o_hs <= s2_hs;
      o_vs <= s2_vs;
      o_bl <= s2_bl;
    end
  end

  assign vid.out_r       = o_r;
  assign vid.out_g       = o_g;
  assign vid.out_b       = o_b;
  assign vid.out_hsync   = o_hs;
  assign vid.out_vsync   = o_vs;
  assign vid.out_blank   = o_bl;
  assign vid.mode_active = mode_active;

endmodule

// File: tb/tb_video_mono_filter.sv
// Directed bench for video_mono_filter: one instance without dither and one with dither,
// both fed the same stimulus, with hand-computed expected outputs.
module tb_video_mono_filter;
  localparam int IN_W  = 6;
  localparam int OUT_W = 3;

  logic clk_vga = 1'b0;
  logic rst_n;
  always #5 clk_vga = ~clk_vga;

  video_mono_filter_if #(.IN_W(IN_W), .OUT_W(OUT_W)) vid_plain ();
  video_mono_filter_if #(.IN_W(IN_W), .OUT_W(OUT_W)) vid_dith ();

  video_mono_filter #(.IN_W(IN_W), .OUT_W(OUT_W), .DITHER_EN(0), .HS_POL(1'b0), .VS_POL(1'b0))
    dut_plain (.clk_vga(clk_vga), .rst_n(rst_n), .vid(vid_plain.slave));

  video_mono_filter #(.IN_W(IN_W), .OUT_W(OUT_W), .DITHER_EN(1), .HS_POL(1'b0), .VS_POL(1'b0))
    dut_dith (.clk_vga(clk_vga), .rst_n(rst_n), .vid(vid_dith.slave));

  int tests_run    = 0;
  int tests_failed = 0;
  int dith_idx     = 0;

  typedef struct {
    bit         chk;
    logic [8:0] rgb;
  } exp_t;
  exp_t dith_q[$];

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Both instances see identical inputs; each call ends 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                               input logic hs, input logic vs, input logic bl, input logic [2:0] m);
    vid_plain.in_r = r;  vid_plain.in_g = g;  vid_plain.in_b = b;
    vid_plain.in_hsync = hs;  vid_plain.in_vsync = vs;  vid_plain.in_blank = bl;
    vid_plain.mode = m;
    vid_dith.in_r = r;   vid_dith.in_g = g;   vid_dith.in_b = b;
    vid_dith.in_hsync = hs;   vid_dith.in_vsync = vs;   vid_dith.in_blank = bl;
    vid_dith.mode = m;
    @(posedge clk_vga);
    #1;
  endtask

  function automatic logic [8:0] plainRgb();
    return {vid_plain.out_r, vid_plain.out_g, vid_plain.out_b};
  endfunction

  function automatic logic [8:0] dithRgb();
    return {vid_dith.out_r, vid_dith.out_g, vid_dith.out_b};
  endfunction

  // Grey pixel for the dither instance; the expectation is checked when it leaves the pipe.
  task automatic applyPixel(input logic [5:0] v, input logic hs, input logic vs, input logic bl,
                            input bit chk, input logic [2:0] e);
    exp_t head;
    dith_q.push_back('{chk, {e, e, e}});
    applyStimulus(v, v, v, hs, vs, bl, 3'd0);
    if (dith_q.size() >= 3) begin
      head = dith_q.pop_front();
      if (head.chk) checkOutput($sformatf("dither_%0d", dith_idx), 16'(dithRgb()), 16'(head.rgb));
      dith_idx++;
    end
  endtask

  logic [2:0] line0 [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
  logic [2:0] line1 [4] = '{3'd1, 3'd0, 3'd1, 3'd0};
  logic       pat_bl [12];
  logic       pat_hs [12];
  logic       pat_vs [12];

  initial begin
    // Reset with green requested: pipeline cleared, mode loaded.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(6'd63, 6'd63, 6'd63, 1'b1, 1'b1, 1'b0, 3'd1);
    checkOutput("reset_rgb",    16'(plainRgb()), 16'd0);
    checkOutput("reset_blank",  16'(vid_plain.out_blank), 16'd1);
    checkOutput("reset_hsync",  16'(vid_plain.out_hsync), 16'd1);
    checkOutput("reset_vsync",  16'(vid_plain.out_vsync), 16'd1);
    checkOutput("reset_mode",   16'(vid_plain.mode_active), 16'd1);
    checkOutput("reset_mode_d", 16'(vid_dith.mode_active), 16'd1);

    // First pixel after release appears on the third edge.
    rst_n = 1'b1;
    applyStimulus(6'd63, 6'd63, 6'd63, 1'b1, 1'b1, 1'b0, 3'd1);
    checkOutput("first_edge1_blank", 16'(vid_plain.out_blank), 16'd1);
    applyStimulus(6'd63, 6'd63, 6'd63, 1'b1, 1'b1, 1'b0, 3'd1);
    checkOutput("first_edge2_blank", 16'(vid_plain.out_blank), 16'd1);
    applyStimulus(6'd63, 6'd63, 6'd63, 1'b1, 1'b1, 1'b0, 3'd1);
    checkOutput("first_edge3_blank", 16'(vid_plain.out_blank), 16'd0);
    checkOutput("green_white", 16'(plainRgb()), 16'(9'b000_111_000));

    // Green, pure red: Y = 3402>>8 = 13 -> 3'b001.
    applyStimulus(6'd63, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 3'd1);
    applyStimulus(6'd63, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 3'd1);
    checkOutput("green_latency_hold", 16'(plainRgb()), 16'(9'b000_111_000));
    applyStimulus(6'd63, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 3'd1);
    checkOutput("green_red", 16'(plainRgb()), 16'(9'b000_001_000));

    // Amber via a vsync edge.
    applyStimulus(6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b0, 3'd2);
    for (int i = 0; i < 2; i++) applyStimulus(6'd63, 6'd63, 6'd63, 1'b1, 1'b1, 1'b0, 3'd2);
    checkOutput("amber_mode",  16'(vid_plain.mode_active), 16'd2);
    checkOutput("amber_white", 16'(plainRgb()), 16'(9'b111_011_000));

    // Inverse white.
    applyStimulus(6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b0, 3'd4);
    for (int i = 0; i < 2; i++) applyStimulus(6'd63, 6'd63, 6'd63, 1'b1, 1'b1, 1'b0, 3'd4);
    checkOutput("inv_white", 16'(plainRgb()), 16'd0);
    for (int i = 0; i < 3; i++) applyStimulus(6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 3'd4);
    checkOutput("inv_black", 16'(plainRgb()), 16'(9'b111_111_111));

    // Colour, then a mid-line request for white that must wait for vsync.
    applyStimulus(6'd63, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) applyStimulus(6'd63, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 3'd0);
    checkOutput("colour_red", 16'(plainRgb()), 16'(9'b111_000_000));
    for (int i = 0; i < 3; i++) applyStimulus(6'd63, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 3'd3);
    checkOutput("midline_rgb",  16'(plainRgb()), 16'(9'b111_000_000));
    checkOutput("midline_mode", 16'(vid_plain.mode_active), 16'd0);
    applyStimulus(6'd63, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 3'd3);
    checkOutput("vs_edge_mode", 16'(vid_plain.mode_active), 16'd3);
    applyStimulus(6'd63, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 3'd3);
    checkOutput("pre_edge_colour", 16'(plainRgb()), 16'(9'b111_000_000));
    applyStimulus(6'd63, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 3'd3);
    checkOutput("post_edge_grey", 16'(plainRgb()), 16'(9'b001_001_001));

    // Dither: colour mode, gray 4, then saturation at 63 on both line parities.
    applyPixel(6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    applyPixel(6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) applyPixel(6'd4, 1'b1, 1'b1, 1'b0, 1'b1, line0[i]);
    applyPixel(6'd4, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    applyPixel(6'd4, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
    applyPixel(6'd4, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 4; i++) applyPixel(6'd4, 1'b1, 1'b1, 1'b0, 1'b1, line1[i]);
    for (int ln = 0; ln < 2; ln++) begin
      applyPixel(6'd63, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
      applyPixel(6'd63, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 4; i++) applyPixel(6'd63, 1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
    end
    applyPixel(6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    applyPixel(6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);

    // Blank, hsync and vsync pulses at distinct cycles, each seen exactly three edges later.
    for (int j = 0; j < 12; j++) begin
      pat_bl[j] = (j == 3) ? 1'b1 : 1'b0;
      pat_hs[j] = (j == 5) ? 1'b0 : 1'b1;
      pat_vs[j] = (j == 7) ? 1'b0 : 1'b1;
    end
    for (int j = 0; j < 12; j++) begin
      applyStimulus(6'd63, 6'd63, 6'd63, pat_hs[j], pat_vs[j], pat_bl[j], 3'd0);
      if (j >= 2) begin
        checkOutput($sformatf("align_blank_%0d", j), 16'(vid_plain.out_blank), 16'(pat_bl[j-2]));
        checkOutput($sformatf("align_hsync_%0d", j), 16'(vid_plain.out_hsync), 16'(pat_hs[j-2]));
        checkOutput($sformatf("align_vsync_%0d", j), 16'(vid_plain.out_vsync), 16'(pat_vs[j-2]));
        checkOutput($sformatf("align_rgb_%0d", j), 16'(plainRgb()),
                    pat_bl[j-2] ? 16'd0 : 16'(9'b111_111_111));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
